dft_serial_engine: RTL and testbench

- Parametrised successor to the combinational N-point DFT word-shuffler; performs the full DFT with real twiddle-factor multiplication.
- Buffers one frame of N real signed samples, then computes complex bins X[k] = sum x[n]·e^(-j2πkn/N) using one time-shared complex multiply-accumulate.
- Streams the bins out in order with valid/ready handshakes on both sides.
- Sits between the sample front end and the spectral post-processing stages.

---
 rtl/dft_serial_engine.sv | 192 +++++++++++++++++++
 tb/tb_dft_serial_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dft_serial_engine.sv
// dft_serial_engine: buffers one frame of N real samples, then computes the
// complex DFT bins one at a time with a single time-shared complex MAC and
// streams them out under a valid/ready handshake.
module dft_serial_engine #(
    parameter int unsigned N       = 8,
    parameter int unsigned WORD_SZ = 8,
    parameter int unsigned TW_SZ   = 8,
    localparam int unsigned LOG2N  = $clog2(N),
    localparam int unsigned OUT_SZ = WORD_SZ + LOG2N + 1
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic [WORD_SZ-1:0]  i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [OUT_SZ-1:0]   o_re,
    output logic [OUT_SZ-1:0]   o_im,
    output logic [LOG2N-1:0]    o_bin,
    output logic                o_last,
    output logic                o_valid,
    input  logic                i_ready
);

    localparam int unsigned PROD_SZ = WORD_SZ + TW_SZ;
    localparam int unsigned ACC_SZ  = PROD_SZ + LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    // +1.0 saturates to the largest positive code; the table stays symmetric
    localparam logic signed [TW_SZ-1:0] TW_ONE = TW_SZ'((64'd1 << (TW_SZ - 1)) - 64'd1);
    // round(2^(TW_SZ-1) / sqrt(2)) using a Q31 constant for 1/sqrt(2)
    localparam logic [63:0] TW_HALF64 =
        ((64'd1 << (TW_SZ - 1)) * 64'd1518500250 + (64'd1 << 30)) >> 31;
    localparam logic signed [TW_SZ-1:0] TW_HALF = TW_SZ'(TW_HALF64);

    // Reject unsupported configurations at elaboration
    if (!(N == 2 || N == 4 || N == 8)) begin : g_bad_n
        $error("dft_serial_engine: N must be 2, 4 or 8");
    end
    if (TW_SZ < 3) begin : g_bad_tw
        $error("dft_serial_engine: TW_SZ must be at least 3");
    end

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                     r_state;
    logic [WORD_SZ-1:0]         r_buf [N];
    logic [LOG2N-1:0]           r_count;
    logic [LOG2N-1:0]           r_k;
    logic [LOG2N-1:0]           r_n;
    logic signed [ACC_SZ-1:0]   r_re_acc;
    logic signed [ACC_SZ-1:0]   r_im_acc;
    logic                       r_ready;
    logic                       r_valid;
    logic                       r_last;
    logic [OUT_SZ-1:0]          r_re;
    logic [OUT_SZ-1:0]          r_im;
    logic [LOG2N-1:0]           r_bin;

    logic                       w_accept;
    logic [LOG2N-1:0]           w_idx;
    logic [2:0]                 w_eighth;
    logic signed [TW_SZ-1:0]    w_cos;
    logic signed [TW_SZ-1:0]    w_sin;
    logic signed [WORD_SZ-1:0]  w_x;
    logic signed [PROD_SZ-1:0]  w_mul_c;
    logic signed [PROD_SZ-1:0]  w_mul_s;
    logic signed [ACC_SZ-1:0]   w_prod_re;
    logic signed [ACC_SZ-1:0]   w_prod_im;
    logic signed [ACC_SZ-1:0]   w_re_base;
    logic signed [ACC_SZ-1:0]   w_im_base;
    logic signed [ACC_SZ-1:0]   w_re_sum;
    logic signed [ACC_SZ-1:0]   w_im_sum;

    assign w_accept = (r_state == S_LOAD) && i_valid && r_ready;

    // Twiddle index (k*n) mod N, rescaled to eighths of a turn
    assign w_idx    = r_k * r_n;
    assign w_eighth = 3'(w_idx) << (3 - LOG2N);

    // Quantised cos/sin lookup by octant
    always_comb begin
        w_cos = '0;
        w_sin = '0;
        case (w_eighth)
            3'd0: begin w_cos =  TW_ONE;  w_sin =  '0;      end
            3'd1: begin w_cos =  TW_HALF; w_sin =  TW_HALF; end
            3'd2: begin w_cos =  '0;      w_sin =  TW_ONE;  end
            3'd3: begin w_cos = -TW_HALF; w_sin =  TW_HALF; end
            3'd4: begin w_cos = -TW_ONE;  w_sin =  '0;      end
            3'd5: begin w_cos = -TW_HALF; w_sin = -TW_HALF; end
            3'd6: begin w_cos =  '0;      w_sin = -TW_ONE;  end
            3'd7: begin w_cos =  TW_HALF; w_sin = -TW_HALF; end
        endcase
    end

    // Complex product x[n]*(C - jS) and the running sums; n = 0 restarts the sum
    assign w_x       = $signed(r_buf[r_n]);
    assign w_mul_c   = PROD_SZ'(w_x) * PROD_SZ'(w_cos);
    assign w_mul_s   = PROD_SZ'(w_x) * PROD_SZ'(w_sin);
    assign w_prod_re = ACC_SZ'(w_mul_c);
    assign w_prod_im = -ACC_SZ'(w_mul_s);
    assign w_re_base = (r_n == '0) ? '0 : r_re_acc;
    assign w_im_base = (r_n == '0) ? '0 : r_im_acc;
    assign w_re_sum  = w_re_base + w_prod_re;
    assign w_im_sum  = w_im_base + w_prod_im;

    // Sample buffer write; contents need no reset since count restarts at 0
    always_ff @(posedge i_CLK) begin
        if (w_accept) begin
            r_buf[r_count] <= i_data;
        end
    end

    // Control FSM with registered handshake and bin outputs
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state  <= S_LOAD;
            r_count  <= '0;
            r_k      <= '0;
            r_n      <= '0;
            r_re_acc <= '0;
            r_im_acc <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_re     <= '0;
            r_im     <= '0;
            r_bin    <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_count == LAST) begin
                            r_count <= '0;
                            r_k     <= '0;
                            r_n     <= '0;
                            r_ready <= 1'b0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_count <= r_count + LOG2N'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    r_re_acc <= w_re_sum;
                    r_im_acc <= w_im_sum;
                    if (r_n == LAST) begin
                        r_n     <= '0;
                        // arithmetic shift right by TW_SZ-1, low OUT_SZ bits kept
                        r_re    <= w_re_sum[TW_SZ-1 +: OUT_SZ];
                        r_im    <= w_im_sum[TW_SZ-1 +: OUT_SZ];
                        r_bin   <= r_k;
                        r_last  <= (r_k == LAST);
                        r_valid <= 1'b1;
                        r_state <= S_OUTPUT;
                    end else begin
                        r_n <= r_n + LOG2N'(1);
                    end
                end
                S_OUTPUT: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_k == LAST) begin
                            r_k     <= '0;
                            r_ready <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_k     <= r_k + LOG2N'(1);
                            r_state <= S_COMPUTE;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_re    = r_re;
    assign o_im    = r_im;
    assign o_bin   = r_bin;

endmodule

// File: tb/tb_dft_serial_engine.sv
// Directed bench for dft_serial_engine (N=8, WORD_SZ=8, TW_SZ=8).
module tb_dft_serial_engine;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [7:0]   i_data;
    logic                i_valid;
    logic                o_ready;
    logic signed [11:0]  o_re;
    logic signed [11:0]  o_im;
    logic [2:0]          o_bin;
    logic                o_last;
    logic                o_valid;
    logic                i_ready;

    int  n_checks = 0;
    int  n_errors = 0;
    int  frame  [8];
    int  exp_re [8];
    int  exp_im [8];
    time t_last_acc;

    always #5 clk = ~clk;

    dft_serial_engine #(.N(8), .WORD_SZ(8), .TW_SZ(8)) dut (
        .i_CLK   (clk),
        .i_RESET (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_re    (o_re),
        .o_im    (o_im),
        .o_bin   (o_bin),
        .o_last  (o_last),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stream nsamp samples from frame[] with i_valid held high
    task automatic send_frame(input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            int guard = 0;
            @(negedge clk);
            while (!o_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                check("ready_timeout", 0, 1);
                i_valid = 1'b0;
                return;
            end
            i_valid = 1'b1;
            i_data  = 8'(frame[i]);
            @(posedge clk);
            t_last_acc = $time;
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Collect the 8 bins and compare against exp_re/exp_im
    task automatic collect(input int stall_b, input int abort_b, input bit inject, input bit timing);
        time t_prev = 0;
        check("ready_low_in_compute", int'(o_ready), 0);
        for (int b = 0; b < 8; b++) begin
            int  guard  = 0;
            bit  seen   = 0;
            bit  stable;
            int  cap_re, cap_im, cap_bin;
            time t_cap;
            while (!seen) begin
                @(negedge clk);
                if (o_valid) begin
                    seen = 1;
                end else begin
                    i_valid = inject;
                    i_data  = 8'sd77;
                    guard++;
                    if (guard > 200) begin
                        check($sformatf("timeout_bin%0d", b), 0, 1);
                        i_valid = 1'b0;
                        return;
                    end
                end
            end
            t_cap   = $time;
            i_valid = inject && (b != 7);
            cap_re  = int'(o_re);
            cap_im  = int'(o_im);
            cap_bin = int'(o_bin);
            check($sformatf("bin_idx%0d", b), cap_bin, b);
            check($sformatf("last_bin%0d", b), int'(o_last), (b == 7) ? 1 : 0);
            check($sformatf("re_bin%0d", b), cap_re, exp_re[b]);
            check($sformatf("im_bin%0d", b), cap_im, exp_im[b]);
            if (timing) begin
                if (b == 0)
                    check("latency", int'((t_cap - t_last_acc - 5) / 10), 8);
                else
                    check($sformatf("spacing_bin%0d", b), int'((t_cap - t_prev) / 10), 9);
            end
            t_prev = t_cap;
            if (b == abort_b) begin
                #2 rst = 1'b1;
                #1;
                check("abort_valid_low", int'(o_valid), 0);
                check("abort_ready_high", int'(o_ready), 1);
                check("abort_last_low", int'(o_last), 0);
                @(negedge clk);
                rst     = 1'b0;
                i_valid = 1'b0;
                return;
            end
            if (b == stall_b) begin
                i_ready = 1'b0;
                stable  = 1;
                repeat (20) begin
                    @(negedge clk);
                    if (!o_valid || int'(o_re) != cap_re || int'(o_im) != cap_im ||
                        int'(o_bin) != cap_bin || o_ready)
                        stable = 0;
                end
                check("stall_hold", int'(stable), 1);
                i_ready = 1'b1;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic quiet(input int ncyc);
        bit seen = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (o_valid) seen = 1;
        end
        check("no_valid_after_reset", int'(seen), 0);
    endtask

    task automatic set_dc();
        frame  = '{10, 10, 10, 10, 10, 10, 10, 10};
        exp_re = '{79, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    task automatic set_imp0();
        frame  = '{16, 0, 0, 0, 0, 0, 0, 0};
        exp_re = '{15, 15, 15, 15, 15, 15, 15, 15};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(o_ready), 1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_last", int'(o_last), 0);
        check("rst_re", int'(o_re), 0);
        check("rst_im", int'(o_im), 0);
        check("rst_bin", int'(o_bin), 0);
        rst = 1'b0;

        // Impulse at n=0: 16*127/128 = 15.875 -> 15 on every bin
        set_imp0();
        send_frame(8);
        collect(-1, -1, 0, 1);

        // DC frame: 8*10*127/128 = 79.375 -> 79 on bin 0 only
        set_dc();
        send_frame(8);
        collect(-1, -1, 0, 1);

        // Impulse of 64 at n=1: X[k] = floor(C[k]/2) + j*floor(-S[k]/2)
        // (bin 4 is floor(-63.5) = -64), stalled on bin 3, stray i_valid pulses
        frame  = '{0, 64, 0, 0, 0, 0, 0, 0};
        exp_re = '{63, 45, 0, -46, -64, -46, 0, 45};
        exp_im = '{0, -46, -64, -46, 0, 45, 63, 45};
        send_frame(8);
        collect(3, -1, 1, 0);

        // Impulse of 32 at n=2; must load from buffer[0] despite the stray pulses
        frame  = '{0, 0, 32, 0, 0, 0, 0, 0};
        exp_re = '{31, 0, -32, 0, 31, 0, -32, 0};
        exp_im = '{0, -32, 0, 31, 0, -32, 0, 31};
        send_frame(8);
        collect(-1, -1, 0, 1);

        // Reset after 5 samples of a partial frame
        frame = '{50, 50, 50, 50, 50, 50, 50, 50};
        send_frame(5);
        #2 rst = 1'b1;
        #1;
        check("midframe_valid_low", int'(o_valid), 0);
        check("midframe_ready_high", int'(o_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        quiet(100);
        set_dc();
        send_frame(8);
        collect(-1, -1, 0, 1);

        // Reset while bin 2 is being presented
        set_imp0();
        send_frame(8);
        collect(-1, 2, 0, 0);
        quiet(100);
        set_dc();
        send_frame(8);
        collect(-1, -1, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
